// File: rtl/nibble_adder_seq.sv
// Nibble-serial add/subtract sequencer.
// One shared 4-bit adder, LS nibble first.

module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] full;

  // plain 4-bit ripple add with carry
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    sum  = full[3:0];
    cout = full[4];
  end

endmodule

module nibble_adder_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t nxt;

  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;
  logic [NIBBLES-1:0][3:0] sum_q;
  logic                    carry_q;
  logic [IW-1:0]           idx;
  logic                    last;
  logic [3:0]              fa_sum;
  logic                    fa_cout;

  assign last = (idx == IW'(NIBBLES - 1));
  assign sum  = sum_q;

  full_adder_4bit u_fa (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next state and status outputs
  always_comb begin
    nxt   = state;
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // operand latch, nibble stepping, result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      idx      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry_q  <= sub ? 1'b1 : cin;
            idx      <= '0;
            sum_q    <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          sum_q[idx] <= fa_sum;
          carry_q    <= fa_cout;
          if (last) begin
            cout     <= fa_cout;
            overflow <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3])
                        && (fa_sum[3] != a_q[NIBBLES-1][3]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
